// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default word width and entry count
//   ptr_width()                     : bits needed to address FIFO_DEPTH entries
//   cnt_width()                     : bits needed to hold 0..FIFO_DEPTH
package sync_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write port, registered read port.
//   clk, rst_n        : clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port, stored on the rising edge
//   rd_en/rd_addr     : read request; rd_data updates on the rising edge
//   rd_data           : registered read data, holds when rd_en is low
module sync_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents need no reset; stale words are never read before written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reads see the array before this edge's write lands, so a simultaneous
  // read and write to the same entry returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with write acknowledge and error flags.
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_in      : write data, stored when wr_en && !full
//   wr_en, rd_en : write / read requests
//   data_out     : registered read data (one-cycle latency, holds otherwise)
//   wr_ack       : previous-cycle write accepted
//   overflow     : previous-cycle write rejected (FIFO full)
//   underflow    : previous-cycle read rejected (FIFO empty)
//   full, almostfull, empty, almostempty : combinational decode of count
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok;
  logic             rd_ok;

  // Depth need not be a power of two, so wrap explicitly at the last entry.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == CNT_FULL);
  assign almostfull  = (count == CNT_AFULL);
  assign empty       = (count == '0);
  assign almostempty = (count == CNT_AEMPTY);

  // Acceptance is judged on the pre-edge state: a full FIFO rejects a write
  // even if a read frees a slot on the same edge, and an empty FIFO rejects
  // a read even if a write fills it on the same edge.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  sync_fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus pushes the expected post-edge
// response of every cycle; a negedge monitor pops and compares.
module tb_sync_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_out;
  logic         wr_ack, overflow, underflow;
  logic         full, almostfull, empty, almostempty;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .almostfull  (almostfull),
    .empty       (empty),
    .almostempty (almostempty)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;
    logic [W-1:0] dout;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout;
  int           checks = 0;
  int           errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: one expected response per clock edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".wr_ack"},      wr_ack,      e.wr_ack);
        chk({e.tag, ".overflow"},    overflow,    e.overflow);
        chk({e.tag, ".underflow"},   underflow,   e.underflow);
        chk({e.tag, ".full"},        full,        e.full);
        chk({e.tag, ".almostfull"},  almostfull,  e.almostfull);
        chk({e.tag, ".empty"},       empty,       e.empty);
        chk({e.tag, ".almostempty"}, almostempty, e.almostempty);
        chk({e.tag, ".data_out"},    data_out,    e.dout);
      end
    end
  end

  // Drive one cycle of requests, predict the response from a queue model,
  // and hand it to the monitor once the edge has happened.
  task automatic step(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    exp_t e;
    bit   wok, rok;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    wok = w && (model_q.size() < D);
    rok = r && (model_q.size() > 0);
    e.tag       = tag;
    e.wr_ack    = wok;
    e.overflow  = w && !wok;
    e.underflow = r && !rok;
    if (rok) model_dout = model_q.pop_front();
    if (wok) model_q.push_back(d);
    e.dout        = model_dout;
    e.full        = (model_q.size() == D);
    e.almostfull  = (model_q.size() == D - 1);
    e.empty       = (model_q.size() == 0);
    e.almostempty = (model_q.size() == 1);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".empty"},       empty,       1'b1);
    chk({tag, ".full"},        full,        1'b0);
    chk({tag, ".almostfull"},  almostfull,  1'b0);
    chk({tag, ".almostempty"}, almostempty, 1'b0);
    chk({tag, ".wr_ack"},      wr_ack,      1'b0);
    chk({tag, ".overflow"},    overflow,    1'b0);
    chk({tag, ".underflow"},   underflow,   1'b0);
    chk({tag, ".data_out"},    data_out,    16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    data_in    = '0;
    model_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    step("idle", 1'b0, 1'b0, 16'h0000);

    // Fill 1..8, then drain in order.
    for (int i = 1; i <= D; i++) step("fill8", 1'b1, 1'b0, W'(i));
    for (int i = 1; i <= D; i++) step("drain8", 1'b0, 1'b1, 16'h0000);

    // Overflow: the rejected 0xBEEF must never come back out.
    for (int i = 1; i <= D; i++) step("fill_ovf", 1'b1, 1'b0, 16'h0100 + W'(i));
    step("overflow", 1'b1, 1'b0, 16'hBEEF);
    for (int i = 1; i <= D; i++) step("drain_ovf", 1'b0, 1'b1, 16'h0000);

    // Underflow on empty, then read+write on empty: only the write goes.
    step("underflow", 1'b0, 1'b1, 16'h0000);
    step("empty_rw", 1'b1, 1'b1, 16'h00AA);
    step("read_aa", 1'b0, 1'b1, 16'h0000);

    // Steady state at count 4 with both pointers wrapping repeatedly.
    for (int i = 0; i < 4; i++) step("fill4", 1'b1, 1'b0, 16'h0200 + W'(i));
    for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b1, 16'h0300 + W'(i));
    for (int i = 0; i < 4; i++) step("drain4", 1'b0, 1'b1, 16'h0000);

    // Read+write on full: only the read goes, count drops to DEPTH-1.
    for (int i = 0; i < D; i++) step("fill_full", 1'b1, 1'b0, 16'h0400 + W'(i));
    step("full_rw", 1'b1, 1'b1, 16'hDEAD);
    for (int i = 0; i < D - 1; i++) step("drain_full", 1'b0, 1'b1, 16'h0000);

    // Asynchronous reset mid-burst at count 5, away from any clock edge.
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, 16'h0500 + W'(i));
    @(negedge clk);
    #2;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_q.delete();
    model_dout = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_idle", 1'b0, 1'b0, 16'h0000);
    step("post_rst_underflow", 1'b0, 1'b1, 16'h0000);
    step("post_rst_write", 1'b1, 1'b0, 16'h0600);
    step("post_rst_read", 1'b0, 1'b1, 16'h0000);
    step("final_idle", 1'b0, 1'b0, 16'h0000);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
